// File: rtl/sample_packet_buffer.sv
// Block-RAM sample FIFO feeding the UDP packet sender: announces each full packet
// with a one-cycle request and reserves those words until the sender has popped them.
module sample_packet_buffer #(
    parameter int ADDR_W    = 10,
    parameter int PKT_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic [31:0]       sample_i,
    input  logic              sample_valid_i,
    output logic [31:0]       fifo_d_o,
    output logic [8:0]        packet_size_o,
    output logic              fifo_req_o,
    input  logic              fifo_rd_i,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PKT_LEVEL  = (ADDR_W + 1)'(PKT_WORDS);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   reserved;

    logic sample_in;
    logic full;
    logic wr_en;
    logic pop;
    logic req_fire;

    // Full is judged on the pre-edge level, so a same-cycle pop never makes room for a write.
    assign sample_in = enable_i & sample_valid_i;
    assign full      = (level == FULL_LEVEL);
    assign wr_en     = sample_in & ~full;
    assign pop       = fifo_rd_i & (level != '0);
    assign req_fire  = (reserved == '0) && (level >= PKT_LEVEL) && !fifo_req_o;

    assign packet_size_o = 9'(PKT_WORDS - 1);
    assign level_o       = level;

    // NOTE: the storage array has no reset so it maps onto block RAM; stale contents are
    // unreachable because the pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_d_o <= '0;
        end else if (pop) begin
            fifo_d_o <= mem[rd_ptr];
        end
    end

    // NOTE: all state here is sequential, so only non-blocking assignments are used.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            reserved    <= '0;
            fifo_req_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            // Pops past the reservation are the sender's look-ahead read; they never wrap reserved.
            if (req_fire) begin
                reserved <= PKT_LEVEL;
            end else if (pop && (reserved != '0)) begin
                reserved <= reserved - 1'b1;
            end

            fifo_req_o <= req_fire;

            if (sample_in && full) begin
                overflow_o <= 1'b1;
            end
            if (fifo_rd_i && (level == '0)) begin
                underflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_packet_buffer.sv
// Directed bench for sample_packet_buffer: a 16-deep instance for packet flow and a
// 8-deep instance for overflow, both with 4-word packets.
module tb_sample_packet_buffer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance: ADDR_W=4, PKT_WORDS=4
    logic        enable, sample_valid, fifo_rd;
    logic [31:0] sample, fifo_d;
    logic [8:0]  packet_size;
    logic        fifo_req, overflow, underflow;
    logic [4:0]  level;

    // Small instance: ADDR_W=3, PKT_WORDS=4
    logic        s_enable, s_sample_valid, s_fifo_rd;
    logic [31:0] s_sample, s_fifo_d;
    logic [8:0]  s_packet_size;
    logic        s_fifo_req, s_overflow, s_underflow;
    logic [3:0]  s_level;

    int n_cmp = 0;
    int n_bad = 0;

    sample_packet_buffer #(.ADDR_W(4), .PKT_WORDS(4)) dut (
        .clk(clk), .reset(reset), .enable_i(enable), .sample_i(sample),
        .sample_valid_i(sample_valid), .fifo_d_o(fifo_d), .packet_size_o(packet_size),
        .fifo_req_o(fifo_req), .fifo_rd_i(fifo_rd), .level_o(level),
        .overflow_o(overflow), .underflow_o(underflow)
    );

    sample_packet_buffer #(.ADDR_W(3), .PKT_WORDS(4)) dut_s (
        .clk(clk), .reset(reset), .enable_i(s_enable), .sample_i(s_sample),
        .sample_valid_i(s_sample_valid), .fifo_d_o(s_fifo_d), .packet_size_o(s_packet_size),
        .fifo_req_o(s_fifo_req), .fifo_rd_i(s_fifo_rd), .level_o(s_level),
        .overflow_o(s_overflow), .underflow_o(s_underflow)
    );

    // One clock edge; outputs are then observed 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", level); end
        n_cmp++; if (fifo_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", fifo_req); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL rst_flags got %b want 00", {overflow, underflow}); end
        n_cmp++; if (fifo_d !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", fifo_d); end
        n_cmp++; if (packet_size !== 9'd3) begin n_bad++; $display("FAIL rst_pkt_size got %0d want 3", packet_size); end
        n_cmp++; if (s_level !== 4'd0) begin n_bad++; $display("FAIL rst_s_level got %0d want 0", s_level); end
        reset = 1'b0;
    endtask

    task automatic test_single_packet();
        // Valid while disabled must be ignored
        enable = 1'b0; sample_valid = 1'b1; sample = 32'hdead;
        tick();
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL dis_level got %0d want 0", level); end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample = 32'h1000 + 32'(i);
            tick();
            n_cmp++; if (level !== 5'(i + 1)) begin n_bad++; $display("FAIL sp_level[%0d] got %0d want %0d", i, level, i + 1); end
            n_cmp++; if (fifo_req !== 1'b0) begin n_bad++; $display("FAIL sp_early_req[%0d] got %b want 0", i, fifo_req); end
        end
        sample_valid = 1'b0;
        tick();
        n_cmp++; if (fifo_req !== 1'b1) begin n_bad++; $display("FAIL sp_req got %b want 1", fifo_req); end
        n_cmp++; if (packet_size !== 9'd3) begin n_bad++; $display("FAIL sp_pkt_size got %0d want 3", packet_size); end
        tick();
        n_cmp++; if (fifo_req !== 1'b0) begin n_bad++; $display("FAIL sp_req_width got %b want 0", fifo_req); end
        for (int i = 0; i < 4; i++) begin
            fifo_rd = 1'b1;
            tick();
            n_cmp++; if (fifo_d !== 32'h1000 + 32'(i)) begin n_bad++; $display("FAIL sp_data[%0d] got %h want %h", i, fifo_d, 32'h1000 + 32'(i)); end
            fifo_rd = 1'b0;
            tick();
            n_cmp++; if (fifo_d !== 32'h1000 + 32'(i)) begin n_bad++; $display("FAIL sp_hold[%0d] got %h want %h", i, fifo_d, 32'h1000 + 32'(i)); end
            n_cmp++; if (fifo_req !== 1'b0) begin n_bad++; $display("FAIL sp_rd_req[%0d] got %b want 0", i, fifo_req); end
        end
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL sp_end_level got %0d want 0", level); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (fifo_req !== 1'b0) begin n_bad++; $display("FAIL sp_no_second_req[%0d] got %b want 0", i, fifo_req); end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        sample_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sample = 32'h2000 + 32'(i);
            tick();
            if (fifo_req === 1'b1) pulses++;
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fifo_req === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL bb_first_pulses got %0d want 1", pulses); end
        n_cmp++; if (level !== 5'd9) begin n_bad++; $display("FAIL bb_level got %0d want 9", level); end
        fifo_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (fifo_d !== 32'h2000 + 32'(i)) begin n_bad++; $display("FAIL bb_data[%0d] got %h want %h", i, fifo_d, 32'h2000 + 32'(i)); end
            n_cmp++; if (fifo_req !== 1'b0) begin n_bad++; $display("FAIL bb_req_during[%0d] got %b want 0", i, fifo_req); end
        end
        fifo_rd = 1'b0;
        tick();
        n_cmp++; if (fifo_req !== 1'b1) begin n_bad++; $display("FAIL bb_second_req got %b want 1", fifo_req); end
        n_cmp++; if (level !== 5'd5) begin n_bad++; $display("FAIL bb_level2 got %0d want 5", level); end
        fifo_rd = 1'b1;
        for (int i = 4; i < 8; i++) begin
            tick();
            n_cmp++; if (fifo_d !== 32'h2000 + 32'(i)) begin n_bad++; $display("FAIL bb_data[%0d] got %h want %h", i, fifo_d, 32'h2000 + 32'(i)); end
        end
        fifo_rd = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fifo_req === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL bb_third_req got %0d pulses want 0", pulses); end
        n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL bb_remain got %0d want 1", level); end
        // Look-ahead pop beyond the reservation
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        n_cmp++; if (fifo_d !== 32'h2008) begin n_bad++; $display("FAIL bb_lookahead got %h want 2008", fifo_d); end
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL bb_empty got %0d want 0", level); end
    endtask

    task automatic test_underflow();
        n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL uf_before got %b want 0", underflow); end
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL uf_flag got %b want 1", underflow); end
        n_cmp++; if (fifo_d !== 32'h2008) begin n_bad++; $display("FAIL uf_data got %h want 2008", fifo_d); end
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL uf_level got %0d want 0", level); end
        tick();
        n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky got %b want 1", underflow); end
    endtask

    task automatic test_overflow();
        s_enable = 1'b1; s_sample_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_sample = 32'h3000 + 32'(i);
            tick();
            if (i == 7) begin
                n_cmp++; if (s_overflow !== 1'b0) begin n_bad++; $display("FAIL of_early got %b want 0", s_overflow); end
            end
            if (i == 8) begin
                n_cmp++; if (s_overflow !== 1'b1) begin n_bad++; $display("FAIL of_set got %b want 1", s_overflow); end
            end
        end
        s_sample_valid = 1'b0;
        n_cmp++; if (s_level !== 4'd8) begin n_bad++; $display("FAIL of_level got %0d want 8", s_level); end
        s_fifo_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (s_fifo_d !== 32'h3000 + 32'(i)) begin n_bad++; $display("FAIL of_data[%0d] got %h want %h", i, s_fifo_d, 32'h3000 + 32'(i)); end
        end
        s_fifo_rd = 1'b0;
        n_cmp++; if (s_level !== 4'd0) begin n_bad++; $display("FAIL of_drained got %0d want 0", s_level); end
        n_cmp++; if (s_overflow !== 1'b1) begin n_bad++; $display("FAIL of_sticky got %b want 1", s_overflow); end
        // Full with simultaneous pop: the write is still rejected
        s_sample_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_sample = 32'h5000 + 32'(i);
            tick();
        end
        s_sample = 32'h50ff; s_fifo_rd = 1'b1;
        tick();
        s_sample_valid = 1'b0; s_fifo_rd = 1'b0;
        n_cmp++; if (s_level !== 4'd7) begin n_bad++; $display("FAIL of_full_pop_level got %0d want 7", s_level); end
        n_cmp++; if (s_fifo_d !== 32'h5000) begin n_bad++; $display("FAIL of_full_pop_data got %h want 5000", s_fifo_d); end
    endtask

    task automatic test_simultaneous();
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample = 32'h4000 + 32'(i);
            tick();
        end
        n_cmp++; if (level !== 5'd5) begin n_bad++; $display("FAIL sim_pre_level got %0d want 5", level); end
        sample = 32'h4005; fifo_rd = 1'b1;
        tick();
        n_cmp++; if (level !== 5'd5) begin n_bad++; $display("FAIL sim_level got %0d want 5", level); end
        n_cmp++; if (fifo_d !== 32'h4000) begin n_bad++; $display("FAIL sim_data got %h want 4000", fifo_d); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sim_overflow got %b want 0", overflow); end
        sample_valid = 1'b0;
        tick();
        fifo_rd = 1'b0;
        n_cmp++; if (fifo_d !== 32'h4001) begin n_bad++; $display("FAIL sim_data2 got %h want 4001", fifo_d); end
    endtask

    task automatic test_reset_mid();
        // Bring level to 6 with two of the reserved packet still outstanding
        sample_valid = 1'b1;
        for (int i = 6; i < 8; i++) begin
            sample = 32'h4000 + 32'(i);
            tick();
        end
        sample_valid = 1'b0;
        n_cmp++; if (level !== 5'd6) begin n_bad++; $display("FAIL rm_pre_level got %0d want 6", level); end
        n_cmp++; if (fifo_req !== 1'b0) begin n_bad++; $display("FAIL rm_pre_req got %b want 0", fifo_req); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rm_level got %0d want 0", level); end
        n_cmp++; if (fifo_req !== 1'b0) begin n_bad++; $display("FAIL rm_req got %b want 0", fifo_req); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL rm_flags got %b want 00", {overflow, underflow}); end
        n_cmp++; if (fifo_d !== 32'h0) begin n_bad++; $display("FAIL rm_data got %h want 0", fifo_d); end
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample = 32'h6000 + 32'(i);
            tick();
        end
        sample_valid = 1'b0;
        tick();
        n_cmp++; if (fifo_req !== 1'b1) begin n_bad++; $display("FAIL rm_fresh_req got %b want 1", fifo_req); end
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        n_cmp++; if (fifo_d !== 32'h6000) begin n_bad++; $display("FAIL rm_fresh_data got %h want 6000", fifo_d); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0; sample_valid = 1'b0; fifo_rd = 1'b0; sample = '0;
        s_enable = 1'b0; s_sample_valid = 1'b0; s_fifo_rd = 1'b0; s_sample = '0;
        #2;
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_underflow();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
